// File: rtl/timer_run_controller_if.sv
// Button, mode and counter-control signals between the board/counter side and timer_run_controller.
// The controller uses the slave modport; the board/counter side uses master.
interface timer_run_controller_if;
  logic       btn_start;
  logic       btn_clear;
  logic       mode_down;
  logic [7:0] preset;
  logic [7:0] count_in;
  logic       cnt_en;
  logic       cnt_clr;
  logic       cnt_load;
  logic       cnt_dir;
  logic [7:0] load_val;
  logic       alarm;
  logic [1:0] state;

  modport master (
    output btn_start, btn_clear, mode_down, preset, count_in,
    input  cnt_en, cnt_clr, cnt_load, cnt_dir, load_val, alarm, state
  );

  modport slave (
    input  btn_start, btn_clear, mode_down, preset, count_in,
    output cnt_en, cnt_clr, cnt_load, cnt_dir, load_val, alarm, state
  );
endinterface

// File: rtl/timer_run_controller.sv
// Run/pause/clear sequencer for the 0..99 timer counter: debounces the buttons, paces count ticks,
// stops at the terminal value and blinks an alarm until acknowledged.
module timer_run_controller #(
  parameter int unsigned TICK_DIV        = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned MAX_COUNT       = 99,
  parameter int unsigned ALARM_HALF      = 12_500_000
) (
  input  logic                   clk_50MHz,
  input  logic                   reset,
  timer_run_controller_if.slave  bus
);

  localparam int PRESC_W = $clog2(TICK_DIV);
  localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int ALARM_W = (ALARM_HALF > 1) ? $clog2(ALARM_HALF) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ALARM_W-1:0] ALARM_LAST = ALARM_W'(ALARM_HALF - 1);
  localparam logic [7:0]         MAX_VAL    = 8'(MAX_COUNT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  // Button bit 0 = start, bit 1 = clear.
  logic [1:0]      r_sync1;
  logic [1:0]      r_sync2;
  logic [1:0]      r_db;
  logic [1:0]      r_evt;
  logic [DB_W-1:0] r_db_cnt [2];

  state_t             r_state;
  logic [PRESC_W-1:0] r_presc;
  logic [ALARM_W-1:0] r_alarm_tmr;
  logic               r_cnt_en;
  logic               r_cnt_clr;
  logic               r_cnt_load;
  logic               r_cnt_dir;
  logic [7:0]         r_load_val;
  logic               r_alarm;

  logic       w_start_evt;
  logic       w_clear_evt;
  logic [7:0] w_preset_sat;
  logic [7:0] w_terminal;
  logic       w_settled;

  assign w_start_evt  = r_evt[0];
  assign w_clear_evt  = r_evt[1];
  assign w_preset_sat = (bus.preset > MAX_VAL) ? MAX_VAL : bus.preset;
  assign w_terminal   = r_cnt_dir ? 8'd0 : MAX_VAL;
  // count_in lags our pulses by one edge, so it is only trusted in a cycle with no pulse out.
  assign w_settled    = !(r_cnt_clr || r_cnt_load || r_cnt_en);

  // NOTE: every register in this design uses non-blocking assignment so all flops
  // update from pre-edge values, matching real hardware regardless of statement order.
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_evt   <= '0;
      for (int b = 0; b < 2; b++) r_db_cnt[b] <= '0;
    end else begin
      r_sync1 <= {bus.btn_clear, bus.btn_start};
      r_sync2 <= r_sync1;
      for (int b = 0; b < 2; b++) begin
        r_evt[b] <= 1'b0;
        if (r_sync2[b] == r_db[b]) begin
          r_db_cnt[b] <= '0;
        end else if (r_db_cnt[b] == DB_LAST) begin
          // Level accepted after DEBOUNCE_CYCLES differing samples; only rising edges are events.
          r_db[b]     <= r_sync2[b];
          r_db_cnt[b] <= '0;
          r_evt[b]    <= r_sync2[b];
        end else begin
          r_db_cnt[b] <= r_db_cnt[b] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_presc     <= '0;
      r_alarm_tmr <= '0;
      r_cnt_en    <= 1'b0;
      r_cnt_clr   <= 1'b0;
      r_cnt_load  <= 1'b0;
      r_cnt_dir   <= 1'b0;
      r_load_val  <= '0;
      r_alarm     <= 1'b0;
    end else begin
      r_cnt_en   <= 1'b0;
      r_cnt_clr  <= 1'b0;
      r_cnt_load <= 1'b0;
      if (w_clear_evt) begin
        r_state     <= S_IDLE;
        r_cnt_clr   <= 1'b1;
        r_alarm     <= 1'b0;
        r_alarm_tmr <= '0;
        r_presc     <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start_evt) begin
              r_state   <= S_RUN;
              r_presc   <= '0;
              r_cnt_dir <= bus.mode_down;
              if (bus.mode_down) begin
                r_load_val <= w_preset_sat;
                r_cnt_load <= 1'b1;
              end else begin
                r_cnt_clr  <= 1'b1;
              end
            end
          end
          S_RUN: begin
            if (w_start_evt) begin
              r_state <= S_PAUSE;
            end else if (w_settled && (bus.count_in == w_terminal)) begin
              r_state     <= S_DONE;
              r_alarm     <= 1'b1;
              r_alarm_tmr <= '0;
            end else begin
              r_presc  <= (r_presc == PRESC_LAST) ? '0 : r_presc + 1'b1;
              r_cnt_en <= (r_presc == PRESC_LAST);
            end
          end
          S_PAUSE: begin
            // Prescaler is left untouched so the tick phase survives the pause.
            if (w_start_evt) r_state <= S_RUN;
          end
          S_DONE: begin
            if (w_start_evt) begin
              r_state     <= S_IDLE;
              r_alarm     <= 1'b0;
              r_alarm_tmr <= '0;
            end else if (r_alarm_tmr == ALARM_LAST) begin
              r_alarm     <= ~r_alarm;
              r_alarm_tmr <= '0;
            end else begin
              r_alarm_tmr <= r_alarm_tmr + 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.cnt_en   = r_cnt_en;
  assign bus.cnt_clr  = r_cnt_clr;
  assign bus.cnt_load = r_cnt_load;
  assign bus.cnt_dir  = r_cnt_dir;
  assign bus.load_val = r_load_val;
  assign bus.alarm    = r_alarm;
  assign bus.state    = r_state;

endmodule

// File: tb/tb_timer_run_controller.sv
// Scoreboard bench for timer_run_controller with a behavioural counter_99 model on count_in.
// Stimulus queues the expected pulse/state events; a negedge monitor pops and compares them.
module tb_timer_run_controller;

  localparam logic [1:0] ST_IDLE = 2'b00, ST_RUN = 2'b01, ST_PAUSE = 2'b10, ST_DONE = 2'b11;

  typedef struct packed {
    logic [1:0] st;
    logic       en;
    logic       clr;
    logic       load;
    logic [7:0] lv;
    logic [7:0] cnt;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] model_cnt = 8'd0;
  int         checks = 0;
  int         failures = 0;
  ev_t        exp_q[$];
  logic [1:0] prev_st = 2'b00;

  timer_run_controller_if bus();

  timer_run_controller #(
    .TICK_DIV(4), .DEBOUNCE_CYCLES(3), .MAX_COUNT(99), .ALARM_HALF(2)
  ) dut (
    .clk_50MHz(clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #10 clk = ~clk;

  // counter_99 model: registered, synchronous clr/load/en, not touched by the controller's reset.
  always @(posedge clk) begin
    if (bus.cnt_clr)       model_cnt <= 8'd0;
    else if (bus.cnt_load) model_cnt <= bus.load_val;
    else if (bus.cnt_en)   model_cnt <= bus.cnt_dir ? model_cnt - 8'd1 : model_cnt + 8'd1;
  end
  assign bus.count_in = model_cnt;

  // Count is don't-care on clr/load cycles; load_val only matters on a load.
  function automatic ev_t mk(input logic [1:0] st, input logic en, input logic clr,
                             input logic load, input logic [7:0] lv, input logic [7:0] cnt);
    ev_t e;
    e.st   = st;
    e.en   = en;
    e.clr  = clr;
    e.load = load;
    e.lv   = load ? lv : 8'd0;
    e.cnt  = (clr || load) ? 8'd0 : cnt;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_state(input string name, input logic [1:0] s, input int budget);
    int n = 0;
    while (bus.state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(bus.state), 32'(s));
  endtask

  task automatic wait_count(input string name, input logic [7:0] v, input int budget);
    int n = 0;
    while (model_cnt !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(model_cnt), 32'(v));
  endtask

  always @(negedge clk) begin
    ev_t obs;
    ev_t exp_e;
    if (reset) begin
      prev_st = 2'b00;
    end else begin
      obs = mk(bus.state, bus.cnt_en, bus.cnt_clr, bus.cnt_load, bus.load_val, bus.count_in);
      if (obs.en || obs.clr || obs.load || obs.st != prev_st) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL event_unexpected: got st=%0d en=%b clr=%b load=%b lv=%0d cnt=%0d at %0t",
                   obs.st, obs.en, obs.clr, obs.load, obs.lv, obs.cnt, $time);
        end else begin
          exp_e = exp_q.pop_front();
          if (obs !== exp_e) begin
            failures++;
            $display("FAIL event: got st=%0d en=%b clr=%b load=%b lv=%0d cnt=%0d expected st=%0d en=%b clr=%b load=%b lv=%0d cnt=%0d at %0t",
                     obs.st, obs.en, obs.clr, obs.load, obs.lv, obs.cnt,
                     exp_e.st, exp_e.en, exp_e.clr, exp_e.load, exp_e.lv, exp_e.cnt, $time);
          end
        end
      end
      prev_st = obs.st;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    logic [4:0] alarm_exp;
    alarm_exp     = 5'b11001;
    bus.btn_start = 1'b1;
    bus.btn_clear = 1'b0;
    bus.mode_down = 1'b0;
    bus.preset    = 8'd0;

    // 1: reset with start held, then exactly one press on release.
    repeat (3) @(negedge clk);
    check("rst_state", 32'(bus.state), 0);
    check("rst_cnt_en", 32'(bus.cnt_en), 0);
    check("rst_cnt_clr", 32'(bus.cnt_clr), 0);
    check("rst_cnt_load", 32'(bus.cnt_load), 0);
    check("rst_cnt_dir", 32'(bus.cnt_dir), 0);
    check("rst_load_val", 32'(bus.load_val), 0);
    check("rst_alarm", 32'(bus.alarm), 0);
    exp_q.push_back(mk(ST_RUN, 0, 1, 0, 8'd0, 8'd0));
    exp_q.push_back(mk(ST_RUN, 1, 0, 0, 8'd0, 8'd0));
    exp_q.push_back(mk(ST_IDLE, 0, 1, 0, 8'd0, 8'd0));
    reset = 1'b0;
    wait_state("t1_run", ST_RUN, 30);
    bus.btn_clear = 1'b1;
    wait_state("t1_clear_idle", ST_IDLE, 30);
    repeat (10) @(negedge clk);
    bus.btn_clear = 1'b0;
    bus.btn_start = 1'b0;
    repeat (10) @(negedge clk);
    check("t1_held_single_event", 32'(bus.state), 32'(ST_IDLE));

    // 2: glitch ignored, then a clean 10-cycle press starts an up count.
    bus.btn_start = 1'b1;
    repeat (2) @(negedge clk);
    bus.btn_start = 1'b0;
    repeat (15) @(negedge clk);
    check("t2_glitch_ignored", 32'(bus.state), 32'(ST_IDLE));
    exp_q.push_back(mk(ST_RUN, 0, 1, 0, 8'd0, 8'd0));
    for (int c = 0; c < 5; c++) exp_q.push_back(mk(ST_RUN, 1, 0, 0, 8'd0, 8'(c)));
    exp_q.push_back(mk(ST_PAUSE, 0, 0, 0, 8'd0, 8'd5));
    bus.btn_start = 1'b1;
    repeat (10) @(negedge clk);
    bus.btn_start = 1'b0;
    check("t2_press_run", 32'(bus.state), 32'(ST_RUN));

    // 3: pause at count 5, then resume at the held prescaler phase.
    wait_count("t3_reach4", 8'd4, 200);
    bus.btn_start = 1'b1;
    wait_state("t3_pause", ST_PAUSE, 20);
    repeat (6) @(negedge clk);
    bus.btn_start = 1'b0;
    repeat (12) @(negedge clk);
    check("t3_pause_count", 32'(model_cnt), 5);
    check("t3_pause_state", 32'(bus.state), 32'(ST_PAUSE));
    exp_q.push_back(mk(ST_RUN, 0, 0, 0, 8'd0, 8'd5));
    for (int c = 5; c < 99; c++) exp_q.push_back(mk(ST_RUN, 1, 0, 0, 8'd0, 8'(c)));
    exp_q.push_back(mk(ST_DONE, 0, 0, 0, 8'd0, 8'd99));
    bus.btn_start = 1'b1;
    wait_state("t3_resume", ST_RUN, 20);
    n = 0;
    while (!bus.cnt_en && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t3_resume_phase", 32'(n), 2);
    repeat (8) @(negedge clk);
    bus.btn_start = 1'b0;

    // 4: up terminal, blinking alarm, acknowledge back to IDLE.
    wait_state("t4_done", ST_DONE, 1000);
    for (int i = 0; i < 5; i++) begin
      check("t4_alarm_seq", 32'(bus.alarm), 32'(alarm_exp[4-i]));
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    check("t4_no_wrap", 32'(model_cnt), 99);
    exp_q.push_back(mk(ST_IDLE, 0, 0, 0, 8'd0, 8'd99));
    bus.btn_start = 1'b1;
    wait_state("t4_ack_idle", ST_IDLE, 20);
    repeat (2) @(negedge clk);
    bus.btn_start = 1'b0;
    check("t4_alarm_off", 32'(bus.alarm), 0);
    repeat (8) @(negedge clk);

    // 5: down from a saturated preset, then preset 0.
    bus.mode_down = 1'b1;
    bus.preset    = 8'd200;
    exp_q.push_back(mk(ST_RUN, 0, 0, 1, 8'd99, 8'd0));
    for (int c = 99; c > 0; c--) exp_q.push_back(mk(ST_RUN, 1, 0, 0, 8'd0, 8'(c)));
    exp_q.push_back(mk(ST_DONE, 0, 0, 0, 8'd0, 8'd0));
    bus.btn_start = 1'b1;
    wait_state("t5_run", ST_RUN, 20);
    bus.preset    = 8'd50;
    bus.mode_down = 1'b0;
    repeat (2) @(negedge clk);
    bus.btn_start = 1'b0;
    wait_state("t5_done", ST_DONE, 1000);
    check("t5_dir_latched", 32'(bus.cnt_dir), 1);
    check("t5_load_val_held", 32'(bus.load_val), 99);
    exp_q.push_back(mk(ST_IDLE, 0, 0, 0, 8'd0, 8'd0));
    bus.btn_start = 1'b1;
    wait_state("t5_idle", ST_IDLE, 20);
    repeat (2) @(negedge clk);
    bus.btn_start = 1'b0;
    repeat (8) @(negedge clk);
    bus.mode_down = 1'b1;
    bus.preset    = 8'd0;
    exp_q.push_back(mk(ST_RUN, 0, 0, 1, 8'd0, 8'd0));
    exp_q.push_back(mk(ST_DONE, 0, 0, 0, 8'd0, 8'd0));
    bus.btn_start = 1'b1;
    wait_state("t5_zero_run", ST_RUN, 20);
    check("t5_zero_load", 32'(bus.cnt_load), 1);
    n = 0;
    while (bus.state !== ST_DONE && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t5_zero_done_latency", 32'(n), 2);
    repeat (2) @(negedge clk);
    bus.btn_start = 1'b0;
    repeat (8) @(negedge clk);
    exp_q.push_back(mk(ST_IDLE, 0, 0, 0, 8'd0, 8'd0));
    bus.btn_start = 1'b1;
    wait_state("t5_zero_idle", ST_IDLE, 20);
    repeat (2) @(negedge clk);
    bus.btn_start = 1'b0;
    bus.mode_down = 1'b0;
    repeat (8) @(negedge clk);

    // 6: clear beats start in the same cycle; async reset mid-RUN.
    exp_q.push_back(mk(ST_RUN, 0, 1, 0, 8'd0, 8'd0));
    for (int c = 0; c < 3; c++) exp_q.push_back(mk(ST_RUN, 1, 0, 0, 8'd0, 8'(c)));
    exp_q.push_back(mk(ST_IDLE, 0, 1, 0, 8'd0, 8'd0));
    bus.btn_start = 1'b1;
    wait_state("t6_run", ST_RUN, 20);
    repeat (2) @(negedge clk);
    bus.btn_start = 1'b0;
    wait_count("t6_reach2", 8'd2, 100);
    bus.btn_start = 1'b1;
    bus.btn_clear = 1'b1;
    wait_state("t6_priority_idle", ST_IDLE, 20);
    repeat (3) @(negedge clk);
    check("t6_count_cleared", 32'(model_cnt), 0);
    repeat (7) @(negedge clk);
    bus.btn_start = 1'b0;
    bus.btn_clear = 1'b0;
    repeat (8) @(negedge clk);
    bus.mode_down = 1'b1;
    bus.preset    = 8'd37;
    exp_q.push_back(mk(ST_RUN, 0, 0, 1, 8'd37, 8'd0));
    bus.btn_start = 1'b1;
    wait_state("t6_run2", ST_RUN, 20);
    bus.btn_start = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("t6_async_state", 32'(bus.state), 0);
    check("t6_async_dir", 32'(bus.cnt_dir), 0);
    check("t6_async_load_val", 32'(bus.load_val), 0);
    check("t6_async_pulses", 32'({bus.cnt_en, bus.cnt_clr, bus.cnt_load, bus.alarm}), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_after_reset_idle", 32'(bus.state), 32'(ST_IDLE));
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
